unpack_pkt_arbiter: RTL

//  Packet-level round-robin arbiter sharing one 32b->7b unpacker between NREQ packet sources.

---
 rtl/unpack_pkt_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/unpack_pkt_arbiter.sv
// Packet-level round-robin arbiter that shares one 32b->7b unpacker between NREQ packet sources.
// The grant is held from sop to eop, and words leave through a single registered ready/valid stage.
module unpack_pkt_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 32,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic [NREQ-1:0]    req_sop,
   input  logic [NREQ-1:0]    req_eop,
   output logic [NREQ-1:0]    req_ready,
   output logic               up_valid,
   output logic [DW-1:0]      up_data,
   output logic               up_sop,
   output logic               up_eop,
   input  logic               up_ready,
   output logic [IDW-1:0]     grant_id,
   output logic               busy,
   output logic               drop_pulse,
   output logic               err_pulse,
   output logic [IDW-1:0]     err_id
);

   typedef enum logic {ARB, LOCK} state_t;

   state_t           state, state_nxt;
   logic [IDW-1:0]   rr_ptr, rr_ptr_nxt, grant_nxt;
   logic             first_word, first_word_nxt;
   logic [NREQ-1:0]  cand;
   logic [IDW-1:0]   arb_start, winner;
   logic             win_found;
   logic             lock, can_load;
   logic             g_valid, g_sop, g_eop, g_acc;
   logic [DW-1:0]    g_data;

   function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
      if (32'(v) == NREQ - 1) return '0;
      return v + IDW'(1);
   endfunction

   function automatic logic [IDW-1:0] rot_idx(input logic [IDW-1:0] base, input int unsigned k);
      int unsigned s;
      s = (32'(base) + k) % NREQ;
      return s[IDW-1:0];
   endfunction

   assign lock      = (state == LOCK);
   assign busy      = lock;
   assign can_load  = !up_valid || up_ready;
   assign g_valid   = req_valid[grant_id];
   assign g_sop     = req_sop[grant_id];
   assign g_eop     = req_eop[grant_id];
   assign g_data    = req_data[32'(grant_id) * DW +: DW];
   assign g_acc     = !rst && lock && g_valid && can_load;
   assign cand      = req_valid & req_sop;
   // On an eop hand-over the search starts past the current owner, so the owner is only picked last.
   assign arb_start = lock ? wrap_inc(grant_id) : rr_ptr;
   assign err_pulse = g_acc && g_sop && !first_word;
   assign err_id    = err_pulse ? grant_id : '0;

   always_comb begin
      winner    = '0;
      win_found = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (!win_found && cand[rot_idx(arb_start, k)]) begin
            winner    = rot_idx(arb_start, k);
            win_found = 1'b1;
         end
      end
   end

   always_comb begin
      req_ready  = '0;
      drop_pulse = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (rst) begin
            req_ready[i] = 1'b0;
         end else if (lock && 32'(grant_id) == i) begin
            req_ready[i] = can_load;
         end else if (req_valid[i] && !req_sop[i]) begin
            req_ready[i] = 1'b1;
            drop_pulse   = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant_id;
      rr_ptr_nxt     = rr_ptr;
      first_word_nxt = first_word;
      case (state)
         ARB: begin
            if (win_found) begin
               grant_nxt      = winner;
               first_word_nxt = 1'b1;
               state_nxt      = LOCK;
            end
         end
         LOCK: begin
            if (g_acc) begin
               first_word_nxt = 1'b0;
               if (g_eop) begin
                  rr_ptr_nxt = wrap_inc(grant_id);
                  if (win_found) begin
                     grant_nxt      = winner;
                     first_word_nxt = 1'b1;
                  end else begin
                     state_nxt = ARB;
                  end
               end
            end
         end
         default: state_nxt = ARB;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ARB;
         rr_ptr     <= '0;
         grant_id   <= '0;
         first_word <= 1'b0;
         up_valid   <= 1'b0;
         up_data    <= '0;
         up_sop     <= 1'b0;
         up_eop     <= 1'b0;
      end else begin
         state      <= state_nxt;
         rr_ptr     <= rr_ptr_nxt;
         grant_id   <= grant_nxt;
         first_word <= first_word_nxt;
         if (can_load) begin
            up_valid <= g_acc;
            if (g_acc) begin
               up_data <= g_data;
               up_sop  <= g_sop;
               up_eop  <= g_eop;
            end
         end
      end
   end

endmodule
